// File: rtl/regfile_wb.sv
// 32x32 register file with a writeback port, a JAL link port, write-through reads
// and a per-register busy scoreboard that raises stall on RAW hazards.
module regfile_wb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite,
    input  logic [4:0]  wAddr,
    input  logic [31:0] wDin,
    input  logic        jal_wr,
    input  logic [31:0] link_pc,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        stall
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam logic [AW-1:0] LINK_REG = AW'(31);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            mask_q;

    logic            alu_we;
    logic            alu_hit1;
    logic            alu_hit2;
    logic            jal_hit1;
    logic            jal_hit2;
    logic            pend1;
    logic            pend2;
    logic            hazard;
    logic            accept;
    logic            hide;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    // The link write owns r31 when both ports target it.
    assign alu_we = RegWrite && (wAddr != '0) && !(jal_wr && (wAddr == LINK_REG));

    // Write-port address matches used by both bypass and hazard clearing
    always_comb begin
        alu_hit1 = RegWrite && (rs1_addr != '0) && (wAddr == rs1_addr);
        alu_hit2 = RegWrite && (rs2_addr != '0) && (wAddr == rs2_addr);
        jal_hit1 = jal_wr && (rs1_addr == LINK_REG);
        jal_hit2 = jal_wr && (rs2_addr == LINK_REG);
    end

    // Write-through read muxes
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1_addr != '0) begin
            if (jal_hit1) begin
                rd1 = link_pc;
            end else if (alu_hit1) begin
                rd1 = wDin;
            end else begin
                rd1 = regs[rs1_addr];
            end
        end
        if (rs2_addr != '0) begin
            if (jal_hit2) begin
                rd2 = link_pc;
            end else if (alu_hit2) begin
                rd2 = wDin;
            end else begin
                rd2 = regs[rs2_addr];
            end
        end
    end

    // A busy source stalls unless its producer is writing back right now.
    always_comb begin
        pend1  = (rs1_addr != '0) && busy[rs1_addr] && !alu_hit1 && !jal_hit1;
        pend2  = (rs2_addr != '0) && busy[rs2_addr] && !alu_hit2 && !jal_hit2;
        hazard = pend1 || pend2;
        accept = issue_valid && !hazard && (issue_rd != '0);
    end

    // Busy update: clear on writeback, then set on accept so the newer producer wins.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (RegWrite && (wAddr != '0)) begin
            clr_mask[wAddr] = 1'b1;
        end
        if (jal_wr) begin
            clr_mask[LINK_REG] = 1'b1;
        end
        if (accept) begin
            set_mask[issue_rd] = 1'b1;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Outputs are held at zero while in reset and for one cycle afterwards.
    assign hide     = !rst_n || mask_q;
    assign rs1_data = hide ? '0 : rd1;
    assign rs2_data = hide ? '0 : rd2;
    assign stall    = hide ? 1'b0 : hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            busy   <= '0;
            mask_q <= 1'b1;
        end else begin
            mask_q <= 1'b0;
            busy   <= busy_next;
            if (alu_we) begin
                regs[wAddr] <= wDin;
            end
            if (jal_wr) begin
                regs[LINK_REG] <= link_pc;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a driver pushes model expectations per cycle,
// a monitor pops them on the falling edge and compares against the DUT.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  wAddr;
    logic [31:0] wDin;
    logic        jal_wr;
    logic [31:0] link_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        stall;

    regfile_wb dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .wAddr(wAddr), .wDin(wDin),
        .jal_wr(jal_wr), .link_pc(link_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        jal;
        logic [31:0] lpc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        iv;
        logic [4:0]  ird;
    } stim_t;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        bit          den;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        dst;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state: architectural registers, outstanding producers, post-reset blanking
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_mask = 1'b1;

    function automatic stim_t idle();
        stim_t s;
        s.rstn = 1'b1; s.rw = 1'b0; s.wa = '0; s.wd = '0; s.jal = 1'b0;
        s.lpc = '0; s.a1 = '0; s.a2 = '0; s.iv = 1'b0; s.ird = '0;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input stim_t s, input logic [4:0] a);
        if (!s.rstn || m_mask || a == 5'd0) return 32'd0;
        if (s.jal && a == 5'd31) return s.lpc;
        if (s.rw && s.wa == a) return s.wd;
        return m_regs[a];
    endfunction

    function automatic bit m_waiting(input stim_t s, input logic [4:0] a);
        if (a == 5'd0 || !m_busy[a]) return 1'b0;
        if (s.rw && s.wa == a) return 1'b0;
        if (s.jal && a == 5'd31) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input stim_t s, input string nm, input bit den,
                         input logic [31:0] d1, input logic [31:0] d2, input logic dst);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst_n = s.rstn; RegWrite = s.rw; wAddr = s.wa; wDin = s.wd; jal_wr = s.jal;
        link_pc = s.lpc; rs1_addr = s.a1; rs2_addr = s.a2; issue_valid = s.iv; issue_rd = s.ird;
        hz    = m_waiting(s, s.a1) || m_waiting(s, s.a2);
        e.r1  = m_read(s, s.a1);
        e.r2  = m_read(s, s.a2);
        e.st  = (!s.rstn || m_mask) ? 1'b0 : hz;
        e.den = den; e.d1 = d1; e.d2 = d2; e.dst = dst; e.nm = nm;
        sb.push_back(e);
        // State after the coming edge
        if (!s.rstn) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_mask = 1'b1;
        end else begin
            m_mask = 1'b0;
            if (s.rw && s.wa != 5'd0) begin
                if (!(s.jal && s.wa == 5'd31)) m_regs[s.wa] = s.wd;
                m_busy[s.wa] = 1'b0;
            end
            if (s.jal) begin
                m_regs[31] = s.lpc;
                m_busy[31] = 1'b0;
            end
            if (s.iv && !hz && s.ird != 5'd0) m_busy[s.ird] = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, ".rs1"},   rs1_data, e.r1);
                chk({e.nm, ".rs2"},   rs2_data, e.r2);
                chk({e.nm, ".stall"}, 32'(stall), 32'(e.st));
                if (e.den) begin
                    chk({e.nm, ".dir_rs1"},   rs1_data, e.d1);
                    chk({e.nm, ".dir_rs2"},   rs2_data, e.d2);
                    chk({e.nm, ".dir_stall"}, 32'(stall), 32'(e.dst));
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cnt;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        rst_n = 1'b0; RegWrite = 1'b0; wAddr = '0; wDin = '0; jal_wr = 1'b0;
        link_pc = '0; rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0;

        s = idle(); s.rstn = 1'b0; s.a1 = 5'd5; s.a2 = 5'd31;
        drive(s, "reset", 1'b1, 32'd0, 32'd0, 1'b0);
        drive(s, "reset2", 1'b1, 32'd0, 32'd0, 1'b0);

        // First cycle after reset: write-through is blanked
        s = idle(); s.rw = 1'b1; s.wa = 5'd5; s.wd = 32'hDEADBEEF; s.a1 = 5'd5; s.a2 = 5'd5;
        drive(s, "post_reset", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd5;
        drive(s, "basic_rd", 1'b1, 32'hDEADBEEF, 32'd0, 1'b0);

        s = idle(); s.rw = 1'b1; s.wa = 5'd0; s.wd = 32'h12345678; s.a1 = 5'd0;
        drive(s, "r0_wr", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd0; s.a2 = 5'd0;
        drive(s, "r0_rd", 1'b1, 32'd0, 32'd0, 1'b0);

        s = idle(); s.rw = 1'b1; s.wa = 5'd7; s.wd = 32'hA5A5A5A5; s.a2 = 5'd7;
        drive(s, "wthru", 1'b1, 32'd0, 32'hA5A5A5A5, 1'b0);

        s = idle(); s.iv = 1'b1; s.ird = 5'd31;
        drive(s, "iss31", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.jal = 1'b1; s.lpc = 32'h00000104; s.rw = 1'b1; s.wa = 5'd31;
        s.wd = 32'hFFFFFFFF; s.a1 = 5'd31;
        drive(s, "jal_conf", 1'b1, 32'h00000104, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd31; s.a2 = 5'd31;
        drive(s, "jal_after", 1'b1, 32'h00000104, 32'h00000104, 1'b0);

        s = idle(); s.iv = 1'b1; s.ird = 5'd9;
        drive(s, "iss9", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd9; s.iv = 1'b1; s.ird = 5'd10;
        drive(s, "haz9", 1'b1, 32'd0, 32'd0, 1'b1);
        s = idle(); s.a1 = 5'd9; s.a2 = 5'd10; s.rw = 1'b1; s.wa = 5'd9; s.wd = 32'h00000099;
        drive(s, "haz9_wb", 1'b1, 32'h00000099, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd9;
        drive(s, "haz9_clr", 1'b1, 32'h00000099, 32'd0, 1'b0);

        s = idle(); s.rw = 1'b1; s.wa = 5'd3; s.wd = 32'h55; s.iv = 1'b1; s.ird = 5'd3;
        drive(s, "r3_wr_iss", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd3;
        drive(s, "r3_busy", 1'b1, 32'h55, 32'd0, 1'b1);
        s = idle(); s.rstn = 1'b0; s.a1 = 5'd3; s.a2 = 5'd9;
        drive(s, "mid_reset", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd3;
        drive(s, "mid_reset_mask", 1'b1, 32'd0, 32'd0, 1'b0);
        s = idle(); s.a1 = 5'd3;
        drive(s, "mid_reset_after", 1'b1, 32'd0, 32'd0, 1'b0);

        // Random traffic over a narrow address set to provoke hazards and collisions
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] pick [6];
            pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2;
            pick[3] = 5'd3; pick[4] = 5'd31; pick[5] = 5'($urandom_range(0, 31));
            s.rstn = ($urandom_range(0, 99) != 0);
            s.rw   = ($urandom_range(0, 9) < 4);
            s.wa   = pick[$urandom_range(0, 5)];
            s.wd   = $urandom;
            s.jal  = ($urandom_range(0, 9) == 0);
            s.lpc  = $urandom;
            s.a1   = pick[$urandom_range(0, 5)];
            s.a2   = pick[$urandom_range(0, 5)];
            s.iv   = ($urandom_range(0, 9) < 4);
            s.ird  = pick[$urandom_range(0, 5)];
            drive(s, "rand", 1'b0, 32'd0, 32'd0, 1'b0);
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
